// File: rtl/regfile_dump_reader.sv
// Streams a latched register-file address range out over valid/ready, one beat per register.
// Latency: first beat valid 2 cycles after the accepted start; 1 beat/cycle while out_ready is high.
// Backpressure: out_ready low holds the presented beat stable; the next register is read only when the output slot frees.
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so a wrapped range covering every register still counts correctly.
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              valid_d, last_d;
    logic [DATA_W-1:0] data_d;
    logic [ADDR_W-1:0] addr_d;
    logic              load, xfer;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        valid_d     = out_valid;
        last_d      = out_last;
        data_d      = out_data;
        addr_d      = out_addr;
        xfer        = out_valid && out_ready;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = RUN;
                    ptr_d       = first_addr;
                    remaining_d = {1'b0, ADDR_W'(last_addr - first_addr)} + REM_ONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d     = IDLE;
                    valid_d     = 1'b0;
                    last_d      = 1'b0;
                    remaining_d = '0;
                end else begin
                    load = (!out_valid || out_ready) && (remaining_q != '0);
                    if (load) begin
                        data_d      = rd_data;
                        addr_d      = ptr_q;
                        valid_d     = 1'b1;
                        last_d      = (remaining_q == REM_ONE);
                        ptr_d       = ptr_q + PTR_ONE;
                        remaining_d = remaining_q - REM_ONE;
                    end else if (xfer) begin
                        // Only reachable once every beat is loaded, so this is the final beat leaving.
                        valid_d = 1'b0;
                        if (out_last) begin
                            last_d  = 1'b0;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                valid_d     = 1'b0;
                last_d      = 1'b0;
                remaining_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            out_valid   <= valid_d;
            out_last    <= last_d;
            out_data    <= data_d;
            out_addr    <= addr_d;
        end
    end

    assign rd_addr = (state_q == RUN) ? ptr_q : '0;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, out_ready;
    logic [AW-1:0] first_addr, last_addr, rd_addr, out_addr;
    logic [DW-1:0] rd_data, out_data;
    logic          out_valid, out_last, busy, done;

    logic [DW-1:0] regs [NREG];
    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr),
        .last_addr(last_addr), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    failures = 0;
    int    done_expected = 0;
    logic  prev_last_xfer = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Reference: a dump is the list of registers first, first+1, ... last (mod NREG),
    // each carrying the register-file contents as known when the list is built.
    task automatic push_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
        int n;
        n = ((int'(l) - int'(f)) % NREG + NREG) % NREG + 1;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.addr = AW'((int'(f) + i) % NREG);
            b.data = regs[b.addr];
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    // Monitor: pops one expected beat per handshake and checks the done pulse placement.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_last_xfer = 1'b0;
        end else begin
            if (done) begin
                check("done_after_last", 64'(prev_last_xfer), 64'd1);
                check("done_expected", 64'(done_expected > 0), 64'd1);
                if (done_expected > 0) done_expected--;
            end else if (prev_last_xfer) begin
                check("done_missing", 64'(done), 64'd1);
            end
            prev_last_xfer = 1'b0;
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected addr=%0d data=%0h required=none", out_addr, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_addr", 64'(out_addr), 64'(mon_e.addr));
                    check("beat_data", 64'(out_data), 64'(mon_e.data));
                    check("beat_last", 64'(out_last), 64'(mon_e.last));
                end
                prev_last_xfer = out_last;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout busy=%0b required=0", name, busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] held, old3;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        for (int i = 0; i < NREG; i++) regs[i] = DW'(i) * 32'h1111;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Basic 4-beat dump with exact cycle timing.
        out_ready = 1'b1;
        push_dump(0, 3);
        done_expected++;
        pulse_start(0, 3);
        @(negedge clk);
        check("t1_c1_valid", 64'(out_valid), 64'd0);
        check("t1_c1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_c2_valid", 64'(out_valid), 64'd1);
        check("t1_c2_addr", 64'(out_addr), 64'd0);
        repeat (3) @(negedge clk);
        check("t1_c5_last", 64'(out_last), 64'd1);
        check("t1_c5_data", 64'(out_data), 64'h3333);
        @(negedge clk);
        check("t1_c6_done", 64'(done), 64'd1);
        check("t1_c6_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_c7_busy", 64'(busy), 64'd0);
        check("t1_c7_done", 64'(done), 64'd0);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < NREG; i++) regs[i] = $urandom;

        // Wrapping range.
        step();
        push_dump(30, 1);
        done_expected++;
        pulse_start(30, 1);
        wait_idle("t2", 100);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // Single beat under a long stall, with an ignored start while busy.
        out_ready = 1'b0;
        push_dump(5, 5);
        done_expected++;
        pulse_start(5, 5);
        step();
        held = out_data;
        check("t3_first_data", 64'(held), 64'(regs[5]));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                first_addr = 5'd10; last_addr = 5'd12; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_data", 64'(out_data), 64'(regs[5]));
            check("t3_hold_last", 64'(out_last), 64'd1);
            check("t3_hold_addr", 64'(out_addr), 64'd5);
        end
        start = 1'b0;
        out_ready = 1'b1;
        wait_idle("t3", 20);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // Held beat keeps its loaded value; a not-yet-loaded register shows the new write.
        out_ready = 1'b0;
        old3 = regs[3];
        pulse_start(3, 4);
        step(); step();
        regs[3] = ~old3;
        regs[4] = $urandom;
        push_dump(3, 4);
        exp_q[exp_q.size() - 2].data = old3;
        done_expected++;
        out_ready = 1'b1;
        wait_idle("tcoh", 20);
        check("tcoh_queue_empty", 64'(exp_q.size()), 64'd0);

        // Full 32-register wrapped dump with random stalls and an ignored start.
        push_dump(1, 0);
        done_expected++;
        pulse_start(1, 0);
        begin
            bit ok;
            ok = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (c == 10) begin
                    first_addr = 5'd7; last_addr = 5'd9; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                step();
                if (!busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            start = 1'b0;
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL t4_timeout busy=%0b required=0", busy);
            end
        end
        out_ready = 1'b1;
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Abort while beat 2 is presented: only beat 1 transfers, no done pulse.
        step();
        exp_q.push_back('{addr: 5'd8, data: regs[8], last: 1'b0});
        pulse_start(8, 15);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_last", 64'(out_last), 64'd0);
        repeat (4) step();
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        push_dump(8, 15);
        done_expected++;
        pulse_start(8, 15);
        wait_idle("t5_restart", 50);
        check("t5_restart_queue_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-dump with a beat presented.
        out_ready = 1'b0;
        pulse_start(16, 27);
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_rd_addr", 64'(rd_addr), 64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        push_dump(20, 22);
        done_expected++;
        pulse_start(20, 22);
        wait_idle("t6_restart", 50);
        step();
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_all_seen", 64'(done_expected), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
